cr_vehicle_detector: RTL and testbench
======================================

# cr_vehicle_detector

Country-road vehicle detector feeding the car-waiting request `x` of the highway/country-road traffic light controller. Synchronizes and debounces the raw stop-line loop sensor, counts waiting vehicles, and decrements on exit-sensor pulses. Drives `x` high while vehicles wait. Watches the controller's `hw`/`cr` light codes so a busy country road cannot hold the highway red indefinitely.

## Interface
- `DEB_CYCLES`, default 4: consecutive synchronized-high cycles needed to accept an arrival; legal range 1..255.
- `CNT_W`, default 4: width of the vehicle queue counter.
- `MAX_GREEN`, default 16: maximum country-green cycles before `x` is forced low; legal range 1..255. Used only with the timeout feature.
- `clk` in 1: single clock, all logic on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `arrive_raw` in 1: raw loop sensor, asynchronous, level high while a vehicle sits on the loop.
- `depart` in 1: synchronous one-cycle pulse per vehicle leaving via the exit sensor.
- `hw` in 2: highway light code from the controller: red=0, green=1, yellow=2.
- `cr` in 2: country light code, same encoding.
- `x` out 1: registered request to the controller.
- `queue_cnt` out CNT_W: vehicles currently waiting.
- `overflow` out 1: sticky; set when an arrival is lost at saturation.
- `timeout` out 1: one-cycle pulse when the green limit forces `x` low.

## Operation
- Synchronizer: 2 flops on `arrive_raw`.
- Debounce: counter increments while the synchronized level is high and clears when it is low. The debounced level sets when the count reaches `DEB_CYCLES`. It clears on the first synchronized low.
- Arrival event: rising edge of the debounced level, one event per vehicle.
- Queue update, all in one edge:
  - arrival alone: +1.
  - depart alone: −1 if nonzero; ignored at 0.
  - arrival and depart together: no change.
  - arrival at all-ones: count holds and `overflow` sets. Only reset clears it.
- FSM, next state computed from the next `queue_cnt`:
  - IDLE (`x`=0): go to REQUEST when the queue becomes nonzero.
  - REQUEST (`x`=1): go to SERVE when `cr`==green. Go to IDLE if the queue becomes 0.
  - SERVE (`x`=1): go to IDLE when the queue becomes 0. Go to HOLDOFF when the green timer reaches `MAX_GREEN`, pulsing `timeout`.
  - HOLDOFF (`x`=0): wait for `hw`==green. Then go to REQUEST if the queue is nonzero, else IDLE.
- Green timer: clears on SERVE entry. Counts cycles with `cr`==green while in SERVE.
- `x` is a flop loaded with the next-state decode: 1 in REQUEST and SERVE.
- Illegal FSM encoding recovers to IDLE on the next edge.

## Timing
- Reset values:
  - `x`=0, `queue_cnt`=0, `overflow`=0, `timeout`=0.
  - FSM in IDLE; sync, debounce and green timer all 0.
- Arrival latency: `arrive_raw` first sampled high at edge E0. `queue_cnt` and `x` update at edge E0+`DEB_CYCLES`+3, provided the input stays high.
- A glitch of `DEB_CYCLES`+1 or fewer cycles at the synchronizer input produces no event.
- Departure latency: `depart` high before edge E updates `queue_cnt` at E. `x` falls at the same edge if the queue reaches 0.
- `timeout` is high for exactly the cycle after the HOLDOFF transition edge.
- Reset mid-operation: everything returns to reset values immediately and asynchronously; the queue is lost.
- After reset deassertion, a held-high `arrive_raw` produces one arrival after the normal latency.

## Configuration
- `CR_DET_TIMEOUT_EN` defined:
  - green timer, HOLDOFF state and `timeout` pulse are present as above.
- `CR_DET_TIMEOUT_EN` undefined:
  - no timer, no HOLDOFF; `timeout` tied 0.
  - SERVE exits only when the queue reaches 0, so `x` stays high while vehicles remain.

## Test plan
Defaults used throughout.
- Reset with `arrive_raw`=1 -> all outputs 0. Release: `queue_cnt`=1 and `x`=1 exactly 7 edges after the first high sample.
- 5-cycle high pulse on `arrive_raw` -> no event; `queue_cnt` stays 0 and `x` stays 0.
- 3 clean arrivals, then `cr`=green, then 3 `depart` pulses -> `queue_cnt` 3→0. `x` falls on the third-depart edge. FSM goes IDLE→REQUEST→SERVE→IDLE.
- Arrival event and `depart` in the same cycle at `queue_cnt`=2 -> stays 2. A `depart` at `queue_cnt`=0 -> stays 0.
- 16 arrivals -> `queue_cnt`=15 and `overflow`=1. The flag remains set after departures until `rst`.
- With `CR_DET_TIMEOUT_EN`, `queue_cnt`=2 and `cr` held green 16 cycles -> `x`=0 and `timeout` pulses once. When `hw` returns to green, `x`=1 again. Without the macro, `x` stays 1 throughout.

Source files
------------

// File: rtl/cr_vehicle_detector.sv
// Country-road vehicle detector: synchronizes/debounces the stop-line loop, counts waiting
// vehicles and drives the car-waiting request x. Define CR_DET_TIMEOUT_EN for the country-green limit.
module cr_vehicle_detector #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 4,
    parameter int MAX_GREEN  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arrive_raw,
    input  logic             depart,
    input  logic [1:0]       hw,
    input  logic [1:0]       cr,
    output logic             x,
    output logic [CNT_W-1:0] queue_cnt,
    output logic             overflow,
    output logic             timeout
);

    localparam logic [1:0] GREEN = 2'd1;
    localparam logic [7:0] DEB_L = 8'(DEB_CYCLES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SERVE   = 2'd2,
        HOLDOFF = 2'd3
    } state_e;

    logic [1:0]       sync_q;
    logic             sync_hi;
    logic [7:0]       deb_cnt_q, deb_cnt_d;
    logic             deb_q, deb_d;
    logic             deb_prev_q;
    logic             arrive_ev;
    logic [CNT_W-1:0] queue_q, queue_d;
    logic             ovf_q, ovf_d;
    state_e           state_q, state_d;
    logic             x_q, x_d;
    logic             timeout_q, timeout_d;

    assign sync_hi = sync_q[1];

    always_comb begin
        deb_cnt_d = '0;
        deb_d     = 1'b0;
        if (sync_hi) begin
            deb_cnt_d = (deb_cnt_q == DEB_L) ? deb_cnt_q : deb_cnt_q + 8'd1;
            deb_d     = deb_q | (deb_cnt_q == DEB_L);
        end
    end

    // The level must still be held on the commit edge, so a pulse only as long as the
    // debounce window plus one cycle never produces an event.
    assign arrive_ev = deb_q & ~deb_prev_q & sync_hi;

    always_comb begin
        queue_d = queue_q;
        ovf_d   = ovf_q;
        if (arrive_ev && !depart) begin
            if (&queue_q) begin
                ovf_d = 1'b1;
            end else begin
                queue_d = queue_q + 1'b1;
            end
        end else if (depart && !arrive_ev && (queue_q != '0)) begin
            queue_d = queue_q - 1'b1;
        end
    end

`ifdef CR_DET_TIMEOUT_EN
    logic [7:0] timer_q, timer_d;
    logic       timer_hit;

    always_comb begin
        timer_d = '0;
        if (state_q == SERVE) begin
            timer_d = timer_q + ((cr == GREEN) ? 8'd1 : 8'd0);
        end
    end

    assign timer_hit = (timer_d >= 8'(MAX_GREEN));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    logic [11:0] unused_cfg;
    assign unused_cfg = {8'(MAX_GREEN), hw, cr};
`endif

    always_comb begin
        state_d   = state_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (queue_d != '0) state_d = REQUEST;
            end
            REQUEST: begin
                if (queue_d == '0) begin
                    state_d = IDLE;
                end else if (cr == GREEN) begin
                    state_d = SERVE;
                end
            end
            SERVE: begin
                if (queue_d == '0) begin
                    state_d = IDLE;
                end
`ifdef CR_DET_TIMEOUT_EN
                else if (timer_hit) begin
                    state_d   = HOLDOFF;
                    timeout_d = 1'b1;
                end
`endif
            end
`ifdef CR_DET_TIMEOUT_EN
            HOLDOFF: begin
                if (hw == GREEN) begin
                    state_d = (queue_d != '0) ? REQUEST : IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        x_d = (state_d == REQUEST) || (state_d == SERVE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= '0;
            deb_cnt_q  <= '0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            queue_q    <= '0;
            ovf_q      <= 1'b0;
            state_q    <= IDLE;
            x_q        <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], arrive_raw};
            deb_cnt_q  <= deb_cnt_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            queue_q    <= queue_d;
            ovf_q      <= ovf_d;
            state_q    <= state_d;
            x_q        <= x_d;
            timeout_q  <= timeout_d;
        end
    end

    assign x         = x_q;
    assign queue_cnt = queue_q;
    assign overflow  = ovf_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_cr_vehicle_detector.sv
// Directed bench for cr_vehicle_detector at default parameters; follows CR_DET_TIMEOUT_EN if defined.
module tb_cr_vehicle_detector;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       arrive_raw = 1'b0;
    logic       depart = 1'b0;
    logic [1:0] hw = 2'd0;
    logic [1:0] cr = 2'd0;
    logic       x;
    logic [3:0] queue_cnt;
    logic       overflow;
    logic       timeout;

    int total = 0;
    int bad   = 0;

`ifdef CR_DET_TIMEOUT_EN
    localparam logic TO_EN = 1'b1;
`else
    localparam logic TO_EN = 1'b0;
`endif

    cr_vehicle_detector dut (
        .clk        (clk),
        .rst        (rst),
        .arrive_raw (arrive_raw),
        .depart     (depart),
        .hw         (hw),
        .cr         (cr),
        .x          (x),
        .queue_cnt  (queue_cnt),
        .overflow   (overflow),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Vehicle held on the loop long enough to register, then cleared from the pipeline.
    task automatic arrive_one();
        arrive_raw = 1'b1;
        step(9);
        arrive_raw = 1'b0;
        step(4);
    endtask

    task automatic depart_one();
        depart = 1'b1;
        step(1);
        depart = 1'b0;
    endtask

    initial begin
        // reset with loop occupied
        arrive_raw = 1'b1;
        step(3);
        check("rst_x", 32'(x), 0);
        check("rst_q", 32'(queue_cnt), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_to", 32'(timeout), 0);
        rst = 1'b0;
        step(7);
        check("lat_q_e6", 32'(queue_cnt), 0);
        check("lat_x_e6", 32'(x), 0);
        step(1);
        check("lat_q_e7", 32'(queue_cnt), 1);
        check("lat_x_e7", 32'(x), 1);
        step(5);
        check("held_one_event", 32'(queue_cnt), 1);
        arrive_raw = 1'b0;
        step(4);
        depart_one();
        check("dep_q0", 32'(queue_cnt), 0);
        check("dep_x0", 32'(x), 0);

        // 5-cycle glitch
        arrive_raw = 1'b1;
        step(5);
        arrive_raw = 1'b0;
        step(8);
        check("glitch_q", 32'(queue_cnt), 0);
        check("glitch_x", 32'(x), 0);

        // three arrivals, served, three departures
        arrive_one();
        arrive_one();
        arrive_one();
        check("three_q", 32'(queue_cnt), 3);
        check("three_x", 32'(x), 1);
        cr = 2'd1;
        step(1);
        check("serve_x", 32'(x), 1);
        cr = 2'd0;
        depart_one();
        check("d1_q", 32'(queue_cnt), 2);
        check("d1_x", 32'(x), 1);
        depart_one();
        check("d2_q", 32'(queue_cnt), 1);
        check("d2_x", 32'(x), 1);
        depart_one();
        check("d3_q", 32'(queue_cnt), 0);
        check("d3_x", 32'(x), 0);

        // arrival and depart on the same edge
        arrive_one();
        arrive_one();
        check("pre_sim_q", 32'(queue_cnt), 2);
        arrive_raw = 1'b1;
        step(7);
        depart = 1'b1;
        step(1);
        depart = 1'b0;
        check("sim_q", 32'(queue_cnt), 2);
        arrive_raw = 1'b0;
        step(4);
        check("sim_q_after", 32'(queue_cnt), 2);
        depart_one();
        depart_one();
        check("drain_q", 32'(queue_cnt), 0);
        check("drain_x", 32'(x), 0);
        depart_one();
        check("dep_at_zero", 32'(queue_cnt), 0);

        // saturation
        repeat (15) arrive_one();
        check("sat15_q", 32'(queue_cnt), 15);
        check("sat15_ovf", 32'(overflow), 0);
        arrive_one();
        check("sat16_q", 32'(queue_cnt), 15);
        check("sat16_ovf", 32'(overflow), 1);
        depart_one();
        check("ovf_sticky_q", 32'(queue_cnt), 14);
        check("ovf_sticky", 32'(overflow), 1);

        // asynchronous reset mid-cycle
        #2;
        rst = 1'b1;
        #1;
        check("arst_q", 32'(queue_cnt), 0);
        check("arst_ovf", 32'(overflow), 0);
        check("arst_x", 32'(x), 0);
        step(2);
        rst = 1'b0;

        // green limit
        arrive_one();
        arrive_one();
        check("to_pre_q", 32'(queue_cnt), 2);
        check("to_pre_x", 32'(x), 1);
        cr = 2'd1;
        hw = 2'd0;
        step(16);
        check("to_e16_x", 32'(x), 1);
        check("to_e16_to", 32'(timeout), 0);
        step(1);
        check("to_e17_x", 32'(x), 32'(!TO_EN));
        check("to_e17_to", 32'(timeout), 32'(TO_EN));
        step(1);
        check("to_e18_x", 32'(x), 32'(!TO_EN));
        check("to_e18_to", 32'(timeout), 0);
        cr = 2'd0;
        hw = 2'd1;
        step(1);
        check("hw_green_x", 32'(x), 1);
        check("hw_green_to", 32'(timeout), 0);
        check("hw_green_q", 32'(queue_cnt), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
